hex_display_scanner: RTL and testbench
======================================

// Module: hex_display_scanner
// PURPOSE
//  Downstream consumer of the 8-bit concatenated ALU byte {a_i,b_i}. Captures the byte
//  on a load strobe and drives a time-multiplexed, active-low 4-digit seven-segment
//  display: digit 0 = low nibble, digit 1 = high nibble, digits 2..3 blanked.
//  Shadow/display double-buffering: a new byte is shown only from a frame boundary (no tearing).
// PARAMETERS
//  REFRESH_DIV  100000  clk cycles each digit is lit (>=2); sims use 4
//  NUM_ANODES   4       physical anodes driven; digits >=2 always off
// PORTS
//  clk_i        in   1  system clock, all state on rising edge
//  rst_ni       in   1  asynchronous active-low reset
//  byte_i       in   8  byte from concatenator ({hi nibble, lo nibble})
//  load_i       in   1  capture byte_i into shadow register this cycle
//  blank_lz_i   in   1  1 = blank digit 1 when hi nibble == 0
//  seg_o        out  7  {g,f,e,d,c,b,a}, active-low, registered
//  dp_o         out  1  decimal point, active-low, constant 1 (off)
//  anode_o      out  NUM_ANODES  digit enables, active-low, registered
//  frame_o      out  1  one-cycle pulse when digit index wraps to 0
// BEHAVIOUR
//  Reset (async, rst_ni=0): cnt=0, idx=0, shadow=8'h00, disp=8'h00, seg_o=7'h7F,
//   anode_o=all 1s, dp_o=1, frame_o=0. Outputs hold these until first post-reset edge.
//  Shadow: load_i=1 at edge -> shadow<=byte_i. Back-to-back loads: last one wins.
//  Refresh counter: cnt counts 0..REFRESH_DIV-1; at REFRESH_DIV-1 next cnt=0 and
//   idx advances 0->1->...->NUM_ANODES-1->0 (wrap). Otherwise idx holds.
//  Frame boundary = edge where idx goes NUM_ANODES-1 -> 0: disp<=shadow (pre-edge value),
//   frame_o=1 for exactly that cycle. load_i on the same edge updates shadow only;
//   that byte is displayed from the following frame.
//  Output stage (registered, 1-cycle latency after idx/disp change):
//   idx=0: anode_o bit0=0, others 1; seg_o=hex(disp[3:0])
//   idx=1: anode_o bit1=0 unless (blank_lz_i && disp[7:4]==0) -> all 1s; seg_o=hex(disp[7:4])
//    or 7'h7F when blanked
//   idx>=2: anode_o all 1s, seg_o=7'h7F
//  Exactly zero or one anode low at any time; never two.
//  hex() active-low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10
//   A=08 b=03 C=46 d=21 E=06 F=0E (7-bit hex values).
//  Reset mid-scan: all state returns to reset values immediately; scan restarts at idx=0,
//   previously loaded byte is lost (display shows 00 after first frame).
//  Initial frame after reset shows disp=00 even if load_i occurs; new byte from frame 2.
// TESTING (REFRESH_DIV=4, NUM_ANODES=4)
//  Reset, no load -> anode_o cycles 1110,1101,1111,1111 each 4 clk; seg_o=40 on digits 0,1;
//   frame_o pulses every 16 clk.
//  load_i with byte_i=8'h3A -> after next frame_o: digit0 seg_o=08 (A), digit1 seg_o=30 (3).
//  blank_lz_i=1, load 8'h07 -> digit0 seg_o=78, digit1 anode_o=1111 & seg_o=7F;
//   blank_lz_i=0 -> digit1 seg_o=40.
//  load 8'hF1 on the exact frame-boundary edge -> current frame keeps old byte, F1 appears
//   next frame (seg 79 / 0E).
//  Loads 8'h12 then 8'h34 in consecutive cycles mid-frame -> next frame shows 34 only.
//  Assert rst_ni low mid-digit-1 -> seg_o=7F, anode_o=1111 same cycle (async);
//   after release scan restarts at digit 0 showing 00.

Source files
------------

// File: rtl/hex_display_scanner_if.sv
// Signal bundle between the byte producer / display pins and hex_display_scanner.
// The master side feeds the byte and controls; the slave (the scanner) drives the display pins.
interface hex_display_scanner_if #(
    parameter int NUM_ANODES = 4
);
    logic [7:0]            byte_i;
    logic                  load_i;
    logic                  blank_lz_i;
    logic [6:0]            seg_o;
    logic                  dp_o;
    logic [NUM_ANODES-1:0] anode_o;
    logic                  frame_o;

    modport master (
        output byte_i,
        output load_i,
        output blank_lz_i,
        input  seg_o,
        input  dp_o,
        input  anode_o,
        input  frame_o
    );

    modport slave (
        input  byte_i,
        input  load_i,
        input  blank_lz_i,
        output seg_o,
        output dp_o,
        output anode_o,
        output frame_o
    );
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexed active-low seven-segment driver for one byte (two hex digits).
// A shadow register takes loads at any time; the displayed copy only changes at frame wrap.
module hex_display_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_ANODES  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    hex_display_scanner_if.slave  bus
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_ANODES > 1) ? $clog2(NUM_ANODES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ANODES - 1);
    localparam logic [6:0]       SEG_OFF  = 7'h7F;

    logic [CNT_W-1:0]      cnt_reg;
    logic [CNT_W-1:0]      cnt_next;
    logic [IDX_W-1:0]      idx_reg;
    logic [IDX_W-1:0]      idx_next;
    logic [7:0]            shadow_reg;
    logic [7:0]            shadow_next;
    logic [7:0]            disp_reg;
    logic [7:0]            disp_next;
    logic [6:0]            seg_reg;
    logic [6:0]            seg_next;
    logic [NUM_ANODES-1:0] anode_reg;
    logic [NUM_ANODES-1:0] anode_next;
    logic                  frame_reg;
    logic                  frame_next;

    logic                  digit_tick;
    logic                  frame_wrap;
    logic                  digit_on;
    logic                  hi_blanked;

    // Active-low {g,f,e,d,c,b,a} glyphs for 0..F.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Refresh timing: digit advances when the dwell counter expires.
    always_comb begin
        digit_tick = (cnt_reg == CNT_LAST);
        frame_wrap = digit_tick && (idx_reg == IDX_LAST);
        cnt_next   = digit_tick ? '0 : cnt_reg + CNT_W'(1);
        idx_next   = idx_reg;
        if (digit_tick) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
        end
    end

    // Shadow takes every load; the display copy samples the pre-edge shadow only at wrap,
    // so a load on the wrap edge itself waits one more frame.
    always_comb begin
        shadow_next = bus.load_i ? bus.byte_i : shadow_reg;
        disp_next   = frame_wrap ? shadow_reg : disp_reg;
        frame_next  = frame_wrap;
    end

    always_comb begin
        hi_blanked = bus.blank_lz_i && (disp_reg[7:4] == 4'h0);
        digit_on   = 1'b0;
        seg_next   = SEG_OFF;
        if (idx_reg == IDX_W'(0)) begin
            digit_on = 1'b1;
            seg_next = hex7(disp_reg[3:0]);
        end else if ((NUM_ANODES > 1) && (idx_reg == IDX_W'(1)) && !hi_blanked) begin
            digit_on = 1'b1;
            seg_next = hex7(disp_reg[7:4]);
        end
    end

    // Only anodes 0 and 1 can ever light, and never at the same time.
    generate
        for (genvar gi = 0; gi < NUM_ANODES; gi++) begin : g_anode
            if (gi < 2) begin : g_live
                assign anode_next[gi] = ~(digit_on && (idx_reg == IDX_W'(gi)));
            end else begin : g_dark
                assign anode_next[gi] = 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg    <= '0;
            idx_reg    <= '0;
            shadow_reg <= 8'h00;
            disp_reg   <= 8'h00;
            seg_reg    <= SEG_OFF;
            anode_reg  <= '1;
            frame_reg  <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            shadow_reg <= shadow_next;
            disp_reg   <= disp_next;
            seg_reg    <= seg_next;
            anode_reg  <= anode_next;
            frame_reg  <= frame_next;
        end
    end

    assign bus.seg_o   = seg_reg;
    assign bus.dp_o    = 1'b1;
    assign bus.anode_o = anode_reg;
    assign bus.frame_o = frame_reg;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with REFRESH_DIV=4, NUM_ANODES=4 (16-cycle frame).
`timescale 1ns/1ps
module tb_hex_display_scanner;
    logic clk_i;
    logic rst_ni;
    int   n_cmp;
    int   n_fail;
    int   edge_n;

    hex_display_scanner_if #(.NUM_ANODES(4)) bus ();

    hex_display_scanner #(
        .REFRESH_DIV(4),
        .NUM_ANODES (4)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One rising edge, then settle 1 ns so registered outputs are stable.
    task automatic step();
        @(posedge clk_i);
        #1;
        edge_n++;
    endtask

    task automatic goto_edge(input int target);
        while (edge_n < target) step();
    endtask

    // Steps one full frame from a frame start, sampling mid-digit-0 and mid-digit-1.
    task automatic capture_frame(output logic [6:0] s0, output logic [6:0] s1,
                                 output logic [3:0] a0, output logic [3:0] a1,
                                 output logic fr);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 2) begin s0 = bus.seg_o; a0 = bus.anode_o; end
            if (i == 6) begin s1 = bus.seg_o; a1 = bus.anode_o; end
            if (i == 16) fr = bus.frame_o;
        end
    endtask

    task automatic test_reset();
        rst_ni         = 1'b0;
        bus.byte_i     = 8'h00;
        bus.load_i     = 1'b0;
        bus.blank_lz_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++; if (bus.seg_o !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h expected 7f", bus.seg_o); end
        n_cmp++; if (bus.anode_o !== 4'hF) begin n_fail++; $display("FAIL reset_anode: got %b expected 1111", bus.anode_o); end
        n_cmp++; if (bus.dp_o !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b expected 1", bus.dp_o); end
        n_cmp++; if (bus.frame_o !== 1'b0) begin n_fail++; $display("FAIL reset_frame: got %b expected 0", bus.frame_o); end
        rst_ni = 1'b1;
        edge_n = 0;
        $display("reset: seg=%h anode=%b dp=%b frame=%b", bus.seg_o, bus.anode_o, bus.dp_o, bus.frame_o);
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_fr;
        int         phase;
        for (int k = 1; k <= 32; k++) begin
            step();
            phase   = ((k - 1) / 4) % 4;
            exp_an  = (phase == 0) ? 4'b1110 : (phase == 1) ? 4'b1101 : 4'b1111;
            exp_seg = (phase < 2) ? 7'h40 : 7'h7F;
            exp_fr  = (k % 16 == 0);
            n_cmp++; if (bus.anode_o !== exp_an) begin n_fail++; $display("FAIL idle_anode edge %0d: got %b expected %b", k, bus.anode_o, exp_an); end
            n_cmp++; if (bus.seg_o !== exp_seg) begin n_fail++; $display("FAIL idle_seg edge %0d: got %h expected %h", k, bus.seg_o, exp_seg); end
            n_cmp++; if (bus.frame_o !== exp_fr) begin n_fail++; $display("FAIL idle_frame edge %0d: got %b expected %b", k, bus.frame_o, exp_fr); end
        end
        $display("idle_scan: 32 edges checked, dp=%b", bus.dp_o);
    endtask

    task automatic test_load_3a();
        logic [6:0] s0, s1;
        logic [3:0] a0, a1;
        logic       fr;
        goto_edge(37);
        bus.byte_i = 8'h3A; bus.load_i = 1'b1;
        step();
        bus.load_i = 1'b0; bus.byte_i = 8'h00;
        goto_edge(48);
        capture_frame(s0, s1, a0, a1, fr);
        n_cmp++; if (s0 !== 7'h08) begin n_fail++; $display("FAIL load3a_d0_seg: got %h expected 08", s0); end
        n_cmp++; if (a0 !== 4'b1110) begin n_fail++; $display("FAIL load3a_d0_anode: got %b expected 1110", a0); end
        n_cmp++; if (s1 !== 7'h30) begin n_fail++; $display("FAIL load3a_d1_seg: got %h expected 30", s1); end
        n_cmp++; if (a1 !== 4'b1101) begin n_fail++; $display("FAIL load3a_d1_anode: got %b expected 1101", a1); end
        n_cmp++; if (fr !== 1'b1) begin n_fail++; $display("FAIL load3a_frame: got %b expected 1", fr); end
        $display("load_3a: d0=%h/%b d1=%h/%b frame=%b", s0, a0, s1, a1, fr);
    endtask

    task automatic test_blank_lz();
        logic [6:0] s0, s1;
        logic [3:0] a0, a1;
        logic       fr;
        bus.blank_lz_i = 1'b1;
        goto_edge(67);
        bus.byte_i = 8'h07; bus.load_i = 1'b1;
        step();
        bus.load_i = 1'b0;
        goto_edge(80);
        capture_frame(s0, s1, a0, a1, fr);
        n_cmp++; if (s0 !== 7'h78) begin n_fail++; $display("FAIL blank_d0_seg: got %h expected 78", s0); end
        n_cmp++; if (s1 !== 7'h7F) begin n_fail++; $display("FAIL blank_d1_seg: got %h expected 7f", s1); end
        n_cmp++; if (a1 !== 4'b1111) begin n_fail++; $display("FAIL blank_d1_anode: got %b expected 1111", a1); end
        $display("blank_lz=1: d0=%h/%b d1=%h/%b", s0, a0, s1, a1);
        bus.blank_lz_i = 1'b0;
        capture_frame(s0, s1, a0, a1, fr);
        n_cmp++; if (s1 !== 7'h40) begin n_fail++; $display("FAIL noblank_d1_seg: got %h expected 40", s1); end
        n_cmp++; if (a1 !== 4'b1101) begin n_fail++; $display("FAIL noblank_d1_anode: got %b expected 1101", a1); end
        $display("blank_lz=0: d0=%h/%b d1=%h/%b", s0, a0, s1, a1);
    endtask

    task automatic test_boundary_load();
        logic [6:0] s0, s1;
        logic [3:0] a0, a1;
        logic       fr;
        goto_edge(127);
        bus.byte_i = 8'hF1; bus.load_i = 1'b1;
        step();
        bus.load_i = 1'b0;
        n_cmp++; if (bus.frame_o !== 1'b1) begin n_fail++; $display("FAIL boundary_frame: got %b expected 1", bus.frame_o); end
        capture_frame(s0, s1, a0, a1, fr);
        n_cmp++; if (s0 !== 7'h78) begin n_fail++; $display("FAIL boundary_old_d0: got %h expected 78", s0); end
        n_cmp++; if (s1 !== 7'h40) begin n_fail++; $display("FAIL boundary_old_d1: got %h expected 40", s1); end
        $display("boundary old frame: d0=%h d1=%h", s0, s1);
        capture_frame(s0, s1, a0, a1, fr);
        n_cmp++; if (s0 !== 7'h79) begin n_fail++; $display("FAIL boundary_new_d0: got %h expected 79", s0); end
        n_cmp++; if (s1 !== 7'h0E) begin n_fail++; $display("FAIL boundary_new_d1: got %h expected 0e", s1); end
        $display("boundary new frame: d0=%h d1=%h", s0, s1);
    endtask

    task automatic test_back_to_back();
        logic [6:0] s0, s1;
        logic [3:0] a0, a1;
        logic       fr;
        goto_edge(162);
        bus.byte_i = 8'h12; bus.load_i = 1'b1;
        step();
        bus.byte_i = 8'h34;
        step();
        bus.load_i = 1'b0; bus.byte_i = 8'h00;
        goto_edge(176);
        capture_frame(s0, s1, a0, a1, fr);
        n_cmp++; if (s0 !== 7'h19) begin n_fail++; $display("FAIL b2b_d0: got %h expected 19", s0); end
        n_cmp++; if (s1 !== 7'h30) begin n_fail++; $display("FAIL b2b_d1: got %h expected 30", s1); end
        $display("back_to_back: d0=%h d1=%h", s0, s1);
    endtask

    task automatic test_reset_mid_scan();
        logic [6:0] s0, s1;
        logic [3:0] a0, a1;
        logic       fr;
        goto_edge(198);
        n_cmp++; if (bus.anode_o !== 4'b1101) begin n_fail++; $display("FAIL pre_rst_anode: got %b expected 1101", bus.anode_o); end
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (bus.seg_o !== 7'h7F) begin n_fail++; $display("FAIL async_rst_seg: got %h expected 7f", bus.seg_o); end
        n_cmp++; if (bus.anode_o !== 4'hF) begin n_fail++; $display("FAIL async_rst_anode: got %b expected 1111", bus.anode_o); end
        $display("async reset: seg=%h anode=%b", bus.seg_o, bus.anode_o);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        edge_n = 0;
        // Load held through the whole first frame: must not appear until frame 2.
        bus.byte_i = 8'h55; bus.load_i = 1'b1;
        capture_frame(s0, s1, a0, a1, fr);
        bus.load_i = 1'b0;
        n_cmp++; if (s0 !== 7'h40) begin n_fail++; $display("FAIL post_rst_d0: got %h expected 40", s0); end
        n_cmp++; if (a0 !== 4'b1110) begin n_fail++; $display("FAIL post_rst_d0_anode: got %b expected 1110", a0); end
        n_cmp++; if (s1 !== 7'h40) begin n_fail++; $display("FAIL post_rst_d1: got %h expected 40", s1); end
        n_cmp++; if (fr !== 1'b1) begin n_fail++; $display("FAIL post_rst_frame: got %b expected 1", fr); end
        capture_frame(s0, s1, a0, a1, fr);
        n_cmp++; if (s0 !== 7'h12) begin n_fail++; $display("FAIL frame2_d0: got %h expected 12", s0); end
        n_cmp++; if (s1 !== 7'h12) begin n_fail++; $display("FAIL frame2_d1: got %h expected 12", s1); end
        $display("post reset: frame2 d0=%h d1=%h", s0, s1);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        edge_n = 0;
        test_reset();
        test_idle_scan();
        test_load_3a();
        test_blank_lz();
        test_boundary_load();
        test_back_to_back();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
